alu_acc_stage: RTL and testbench

Result/accumulator stage downstream of the 16-bit ALU datapath. Captures each ALU result under a valid/ready handshake and updates a 16-bit accumulator according to a per-result mode. Feeds the accumulator back to the operand input registers as `acc_val`. Queues each produced value with Z/N/C/V status flags in a small FIFO for the consumer.

---
 rtl/alu_acc_stage.sv | 123 ++++++++++++
 tb/tb_alu_acc_stage.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_acc_stage.sv
// rtl/alu_acc_stage.sv - ALU result capture, 16-bit accumulator and flagged output FIFO
// Define ALU_ACC_SAT_EN to make ACCUM saturate unsigned at 16'hFFFF instead of wrapping.
module alu_acc_stage #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     res_valid,
    output logic                     res_ready,
    input  logic [WIDTH-1:0]         res_data,
    input  logic                     res_carry,
    input  logic [1:0]               acc_mode,
    output logic [WIDTH-1:0]         acc_val,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [3:0]               out_flags,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] MODE_LOAD  = 2'b00;
    localparam logic [1:0] MODE_ACCUM = 2'b01;
    localparam logic [1:0] MODE_PASS  = 2'b10;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic [WIDTH+3:0] mem [DEPTH];

    logic             full;
    logic             accept;
    logic             push;
    logic             pop;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] push_data;
    logic             push_c;
    logic             push_v;
    logic [3:0]       push_flags;

    // res_ready comes only from registered occupancy, never from out_ready
    assign full      = (cnt == CW'(DEPTH));
    assign res_ready = !full;
    assign accept    = res_valid && res_ready;
    assign out_valid = (cnt != '0);
    assign pop       = out_valid && out_ready;
    assign sum       = {1'b0, acc} + {1'b0, res_data};

    always_comb begin
        acc_next  = acc;
        push_data = res_data;
        push_c    = res_carry;
        push_v    = 1'b0;
        push      = 1'b0;
        case (acc_mode)
            MODE_LOAD: begin
                acc_next = res_data;
                push     = accept;
            end
            MODE_ACCUM: begin
                push_c = sum[WIDTH];
                // V always reflects the unsaturated sum
                push_v = (acc[WIDTH-1] == res_data[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);
`ifdef ALU_ACC_SAT_EN
                push_data = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
                push_data = sum[WIDTH-1:0];
`endif
                acc_next = push_data;
                push     = accept;
            end
            MODE_PASS: begin
                push = accept;
            end
            default: begin
                acc_next = '0;
            end
        endcase
        push_flags = {(push_data == '0), push_data[WIDTH-1], push_c, push_v};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (accept) begin
                acc <= acc_next;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {push_data, push_flags};
        end
    end

    // Head is forced to zero when empty so reset and idle show a clean value
    assign out_data  = out_valid ? mem[rd_ptr][WIDTH+3:4] : '0;
    assign out_flags = out_valid ? mem[rd_ptr][3:0] : 4'h0;
    assign acc_val   = acc;
    assign count     = cnt;

endmodule

// File: tb/tb_alu_acc_stage.sv
// tb/tb_alu_acc_stage.sv - directed and randomized checks of alu_acc_stage against a queue model
module tb_alu_acc_stage;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_carry;
    logic [1:0]  acc_mode;
    logic [15:0] acc_val;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_flags;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;

    int          m_acc;
    logic [19:0] m_q[$];

    alu_acc_stage #(.WIDTH(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_carry(res_carry), .acc_mode(acc_mode), .acc_val(acc_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_flags(out_flags), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: drive at negedge, let the edge happen, update the model, return at next negedge
    task automatic cycle(input logic v, input logic [15:0] d, input logic c,
                         input logic [1:0] m, input logic ordy);
        bit          acc_ok;
        bit          pop_ok;
        bit          do_push;
        int          s;
        int          sa;
        int          sd;
        logic [15:0] val;
        logic        cf;
        logic        vf;
        res_valid = v;
        res_data  = d;
        res_carry = c;
        acc_mode  = m;
        out_ready = ordy;
        acc_ok  = v && (m_q.size() < DEPTH);
        pop_ok  = ordy && (m_q.size() > 0);
        do_push = 1'b0;
        val = d;
        cf  = c;
        vf  = 1'b0;
        if (acc_ok) begin
            case (m)
                2'd0: begin m_acc = d; do_push = 1'b1; end
                2'd1: begin
                    s  = m_acc + d;
                    cf = (s > 65535);
                    sa = (m_acc > 32767) ? m_acc - 65536 : m_acc;
                    sd = (d > 32767) ? int'(d) - 65536 : int'(d);
                    vf = ((sa + sd) > 32767) || ((sa + sd) < -32768);
`ifdef ALU_ACC_SAT_EN
                    m_acc = cf ? 65535 : s % 65536;
`else
                    m_acc = s % 65536;
`endif
                    val = 16'(m_acc);
                    do_push = 1'b1;
                end
                2'd2: do_push = 1'b1;
                default: m_acc = 0;
            endcase
        end
        @(posedge clk);
        if (pop_ok) void'(m_q.pop_front());
        if (do_push) m_q.push_back({val, (val == 16'h0), val[15], cf, vf});
        @(negedge clk);
    endtask

    task automatic do_reset();
        res_valid = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_q.delete();
        m_acc = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        tests++;
        if ({acc_val, count, out_valid, res_ready, out_data, out_flags} !== {16'h0, 3'd0, 1'b0, 1'b1, 16'h0, 4'h0}) begin
            fails++;
            $display("FAIL reset_initial: acc=%h count=%0d ov=%b rdy=%b data=%h flags=%h, want 0/0/0/1/0/0",
                     acc_val, count, out_valid, res_ready, out_data, out_flags);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_q.delete();
        m_acc = 0;
        cycle(1, 16'h1234, 0, 2'd0, 0);
        cycle(1, 16'h0001, 1, 2'd2, 0);
        cycle(1, 16'h0002, 0, 2'd2, 0);
        tests++;
        if ({acc_val, count, out_valid} !== {16'h1234, 3'd3, 1'b1}) begin
            fails++;
            $display("FAIL reset_preload: acc=%h count=%0d ov=%b, want 1234/3/1", acc_val, count, out_valid);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({acc_val, count, out_valid, res_ready} !== {16'h0, 3'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_midstream: acc=%h count=%0d ov=%b rdy=%b, want 0/0/0/1",
                     acc_val, count, out_valid, res_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_q.delete();
        m_acc = 0;
    endtask

    task automatic test_accum_chain();
        logic [19:0] exp3;
`ifdef ALU_ACC_SAT_EN
        exp3 = {16'hFFFF, 4'b0110};
`else
        exp3 = {16'h0000, 4'b1010};
`endif
        do_reset();
        cycle(1, 16'h0005, 0, 2'd0, 1);
        tests++;
        if ({acc_val, out_valid, out_data, out_flags} !== {16'h5, 1'b1, 16'h5, 4'b0000}) begin
            fails++;
            $display("FAIL chain_load: acc=%h ov=%b head=%h/%b, want 0005/1/0005/0000", acc_val, out_valid, out_data, out_flags);
        end
        cycle(1, 16'h0003, 0, 2'd1, 1);
        tests++;
        if ({acc_val, out_valid, out_data, out_flags, count} !== {16'h8, 1'b1, 16'h8, 4'b0000, 3'd1}) begin
            fails++;
            $display("FAIL chain_accum1: acc=%h ov=%b head=%h/%b count=%0d, want 0008/1/0008/0000/1",
                     acc_val, out_valid, out_data, out_flags, count);
        end
        cycle(1, 16'hFFF8, 0, 2'd1, 1);
        tests++;
        if ({acc_val, out_valid, out_data, out_flags} !== {exp3[19:4], 1'b1, exp3}) begin
            fails++;
            $display("FAIL chain_accum2: acc=%h ov=%b head=%h/%b, want %h/1/%h/%b",
                     acc_val, out_valid, out_data, out_flags, exp3[19:4], exp3[19:4], exp3[3:0]);
        end
        cycle(0, 16'h0, 0, 2'd0, 1);
    endtask

    task automatic test_overflow();
        do_reset();
        cycle(1, 16'h7FFF, 0, 2'd0, 1);
        cycle(1, 16'h0001, 0, 2'd1, 1);
        tests++;
        if ({acc_val, out_valid, out_data, out_flags} !== {16'h8000, 1'b1, 16'h8000, 4'b0101}) begin
            fails++;
            $display("FAIL signed_overflow: acc=%h ov=%b head=%h/%b, want 8000/1/8000/0101",
                     acc_val, out_valid, out_data, out_flags);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 1; i <= 4; i++) cycle(1, 16'(i), 0, 2'd2, 0);
        res_valid = 1'b1;
        res_data  = 16'h5;
        acc_mode  = 2'd0;
        #1;
        tests++;
        if ({count, res_ready, out_data} !== {3'd4, 1'b0, 16'h1}) begin
            fails++;
            $display("FAIL full_state: count=%0d rdy=%b head=%h, want 4/0/0001", count, res_ready, out_data);
        end
        @(negedge clk);
        cycle(1, 16'h5, 0, 2'd0, 0);
        tests++;
        if ({count, res_ready, acc_val, out_data} !== {3'd4, 1'b0, 16'h0, 16'h1}) begin
            fails++;
            $display("FAIL full_hold: count=%0d rdy=%b acc=%h head=%h, want 4/0/0000/0001", count, res_ready, acc_val, out_data);
        end
        cycle(1, 16'h5, 0, 2'd0, 1);
        tests++;
        if ({count, res_ready, acc_val, out_data} !== {3'd3, 1'b1, 16'h0, 16'h2}) begin
            fails++;
            $display("FAIL full_pop: count=%0d rdy=%b acc=%h head=%h, want 3/1/0000/0002", count, res_ready, acc_val, out_data);
        end
        cycle(1, 16'h5, 0, 2'd0, 0);
        tests++;
        if ({count, res_ready, acc_val} !== {3'd4, 1'b0, 16'h5}) begin
            fails++;
            $display("FAIL full_accept5: count=%0d rdy=%b acc=%h, want 4/0/0005", count, res_ready, acc_val);
        end
        for (int k = 2; k <= 5; k++) begin
            tests++;
            if ({out_valid, out_data} !== {1'b1, 16'(k)}) begin
                fails++;
                $display("FAIL full_drain: ov=%b head=%h, want 1/%h", out_valid, out_data, 16'(k));
            end
            cycle(0, 16'h0, 0, 2'd0, 1);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            cycle(1, 16'(k), 0, 2'd2, 1);
            tests++;
            if ({out_valid, count, out_data} !== {1'b1, 3'd1, 16'(k)}) begin
                fails++;
                $display("FAIL wrap_stream: ov=%b count=%0d head=%h, want 1/1/%h", out_valid, count, out_data, 16'(k));
            end
        end
        cycle(0, 16'h0, 0, 2'd0, 1);
        tests++;
        if ({out_valid, count} !== {1'b0, 3'd0}) begin
            fails++;
            $display("FAIL wrap_drain: ov=%b count=%0d, want 0/0", out_valid, count);
        end
    endtask

    task automatic test_clear();
        do_reset();
        cycle(1, 16'h00AA, 0, 2'd0, 0);
        cycle(1, 16'h0000, 0, 2'd3, 0);
        tests++;
        if ({acc_val, count, out_data} !== {16'h0, 3'd1, 16'h00AA}) begin
            fails++;
            $display("FAIL clear_basic: acc=%h count=%0d head=%h, want 0000/1/00AA", acc_val, count, out_data);
        end
        cycle(1, 16'h0011, 0, 2'd0, 0);
        cycle(1, 16'h0022, 0, 2'd2, 0);
        cycle(1, 16'h0033, 0, 2'd2, 0);
        cycle(1, 16'h0000, 0, 2'd3, 0);
        tests++;
        if ({acc_val, count, res_ready} !== {16'h0011, 3'd4, 1'b0}) begin
            fails++;
            $display("FAIL clear_blocked: acc=%h count=%0d rdy=%b, want 0011/4/0", acc_val, count, res_ready);
        end
        cycle(1, 16'h0000, 0, 2'd3, 1);
        cycle(1, 16'h0000, 0, 2'd3, 0);
        tests++;
        if ({acc_val, count} !== {16'h0, 3'd3}) begin
            fails++;
            $display("FAIL clear_after_full: acc=%h count=%0d, want 0000/3", acc_val, count);
        end
    endtask

    task automatic test_random();
        logic [15:0] d;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0: d = 16'h0000;
                1: d = 16'hFFFF;
                2: d = 16'h8000;
                3: d = 16'h7FFF;
                default: d = 16'($urandom);
            endcase
            cycle(($urandom_range(0, 9) < 7), d, 1'($urandom), 2'($urandom),
                  ($urandom_range(0, 9) < 5));
            tests++;
            if ({acc_val, count, out_valid, res_ready} !==
                {16'(m_acc), 3'(m_q.size()), (m_q.size() > 0), (m_q.size() < DEPTH)}) begin
                fails++;
                $display("FAIL random_state[%0d]: acc=%h count=%0d ov=%b rdy=%b, want %h/%0d",
                         i, acc_val, count, out_valid, res_ready, 16'(m_acc), m_q.size());
            end
            if (m_q.size() > 0) begin
                tests++;
                if ({out_data, out_flags} !== m_q[0]) begin
                    fails++;
                    $display("FAIL random_head[%0d]: head=%h/%b, want %h/%b",
                             i, out_data, out_flags, m_q[0][19:4], m_q[0][3:0]);
                end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        res_valid = 1'b0;
        res_data  = 16'h0;
        res_carry = 1'b0;
        acc_mode  = 2'd0;
        out_ready = 1'b0;
        m_acc     = 0;
        @(negedge clk);
        test_reset();
        test_accum_chain();
        test_overflow();
        test_full();
        test_back_to_back();
        test_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
